// File: rtl/user_flash_programmer_pkg.sv
// Shared definitions for the user flash programmer: FSM states, flash timing in ns and
// ns-to-cycle conversion. Defining FLASH_PROG_VERIFY_EN adds the read-back verify states.
package user_flash_pkg;

  localparam int unsigned TIMER_W = 26;

  localparam longint unsigned T_NVS   = 64'd5_000;
  localparam longint unsigned T_PGS   = 64'd10_000;
  localparam longint unsigned T_PROG  = 64'd16_000;
  localparam longint unsigned T_NVH   = 64'd5_000;
  localparam longint unsigned T_NVH1  = 64'd100_000;
  localparam longint unsigned T_RCV   = 64'd10_000;
  localparam longint unsigned T_RCVE  = 64'd50_000;
  localparam longint unsigned T_ERASE = 64'd120_000_000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PGS,
    ST_PROG,
    ST_PGH,
    ST_ERASE,
    ST_NVH,
    ST_RCV,
`ifdef FLASH_PROG_VERIFY_EN
    ST_VSEL,
    ST_VRD,
    ST_VCMP,
`endif
    ST_DONE
  } flash_state_e;

  // Returns the timer load value (cycles - 1) so a state lasts ceil(t*f) cycles, at least one.
  function automatic logic [TIMER_W-1:0] delay_load(input longint unsigned t_ns,
                                                    input int unsigned clk_hz);
    longint unsigned cycles;
    cycles = (t_ns * 64'(clk_hz) + 64'd999_999_999) / 64'd1_000_000_000;
    if (cycles == 64'd0) cycles = 64'd1;
    if (cycles > (64'd1 << TIMER_W)) cycles = 64'd1 << TIMER_W;
    return TIMER_W'(cycles - 64'd1);
  endfunction

endpackage

// File: rtl/user_flash_programmer_if.sv
// Request/response bus between the flash arbiter (master) and the user flash programmer (slave).
interface user_flash_programmer_if;
  logic        select;
  logic        erase_sel;
  logic [3:0]  wstrb;
  logic [14:0] addr;
  logic [31:0] data_i;
  logic        ready;
  logic        busy;
  logic        error;

  modport master (
    output select, erase_sel, wstrb, addr, data_i,
    input  ready, busy, error
  );

  modport slave (
    input  select, erase_sel, wstrb, addr, data_i,
    output ready, busy, error
  );
endinterface

// File: rtl/user_flash_programmer_delay_timer.sv
// Shared down-counter for all flash phase delays; done is high while the count is zero.
module flash_delay_timer
  import user_flash_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] count,
  output logic               done
);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = count;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/user_flash_programmer.sv
// Word program / row erase sequencer for the user flash macro control pins.
// Optional read-back verify after program is built in with FLASH_PROG_VERIFY_EN.
module user_flash_programmer
  import user_flash_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 27_000_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  user_flash_programmer_if.slave  bus,
  output logic                    xe,
  output logic                    ye,
  output logic                    se,
  output logic                    prog,
  output logic                    erase,
  output logic                    nvstr,
  output logic [8:0]              xadr,
  output logic [5:0]              yadr,
  output logic [31:0]             din,
  input  logic [31:0]             dout
);

  localparam logic [TIMER_W-1:0] LD_NVS   = delay_load(T_NVS,   CLK_FREQ);
  localparam logic [TIMER_W-1:0] LD_PGS   = delay_load(T_PGS,   CLK_FREQ);
  localparam logic [TIMER_W-1:0] LD_PROG  = delay_load(T_PROG,  CLK_FREQ);
  localparam logic [TIMER_W-1:0] LD_NVH   = delay_load(T_NVH,   CLK_FREQ);
  localparam logic [TIMER_W-1:0] LD_NVH1  = delay_load(T_NVH1,  CLK_FREQ);
  localparam logic [TIMER_W-1:0] LD_RCV   = delay_load(T_RCV,   CLK_FREQ);
  localparam logic [TIMER_W-1:0] LD_RCVE  = delay_load(T_RCVE,  CLK_FREQ);
  localparam logic [TIMER_W-1:0] LD_ERASE = delay_load(T_ERASE, CLK_FREQ);

  flash_state_e       state_q, state_d;
  logic [8:0]         row_q, row_d;
  logic [5:0]         col_q, col_d;
  logic [31:0]        data_q, data_d;
  logic               erase_op_q, erase_op_d;
  logic               err_q, err_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_count;
  logic               tmr_done;

  flash_delay_timer u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmr_load),
    .count   (tmr_count),
    .done    (tmr_done)
  );

  // Each timed state loads the timer for its own duration on the transition into it.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    data_d     = data_q;
    erase_op_d = erase_op_q;
    err_d      = err_q;
    tmr_load   = 1'b0;
    tmr_count  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.select) begin
          if (!bus.erase_sel && (bus.wstrb != 4'hF)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            row_d      = bus.addr[14:6];
            col_d      = bus.addr[5:0];
            data_d     = bus.data_i;
            erase_op_d = bus.erase_sel;
            err_d      = 1'b0;
            state_d    = ST_SETUP;
            tmr_load   = 1'b1;
            tmr_count  = LD_NVS;
          end
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          state_d   = ST_PGS;
          tmr_load  = 1'b1;
          tmr_count = erase_op_q ? '0 : LD_PGS;
        end
      end
      ST_PGS: begin
        if (tmr_done) begin
          state_d   = erase_op_q ? ST_ERASE : ST_PROG;
          tmr_load  = 1'b1;
          tmr_count = erase_op_q ? LD_ERASE : LD_PROG;
        end
      end
      ST_PROG: begin
        if (tmr_done) begin
          state_d   = ST_PGH;
          tmr_load  = 1'b1;
          tmr_count = '0;
        end
      end
      ST_PGH: begin
        if (tmr_done) begin
          state_d   = ST_NVH;
          tmr_load  = 1'b1;
          tmr_count = LD_NVH;
        end
      end
      ST_ERASE: begin
        if (tmr_done) begin
          state_d   = ST_NVH;
          tmr_load  = 1'b1;
          tmr_count = LD_NVH1;
        end
      end
      ST_NVH: begin
        if (tmr_done) begin
          state_d   = ST_RCV;
          tmr_load  = 1'b1;
          tmr_count = erase_op_q ? LD_RCVE : LD_RCV;
        end
      end
      ST_RCV: begin
        if (tmr_done) begin
`ifdef FLASH_PROG_VERIFY_EN
          state_d = erase_op_q ? ST_DONE : ST_VSEL;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef FLASH_PROG_VERIFY_EN
      ST_VSEL: state_d = ST_VRD;
      ST_VRD:  state_d = ST_VCMP;
      ST_VCMP: begin
        if (dout != data_q) err_d = 1'b1;
        state_d = ST_DONE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      data_q     <= '0;
      erase_op_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      data_q     <= data_d;
      erase_op_q <= erase_op_d;
      err_q      <= err_d;
    end
  end

  // Flash controls decode purely from the registered state, so reset clears them at once.
  always_comb begin
    xe    = 1'b0;
    ye    = 1'b0;
    se    = 1'b0;
    prog  = 1'b0;
    erase = 1'b0;
    nvstr = 1'b0;
    unique case (state_q)
      ST_SETUP: begin
        xe    = 1'b1;
        prog  = !erase_op_q;
        erase = erase_op_q;
      end
      ST_PGS: begin
        xe    = 1'b1;
        prog  = !erase_op_q;
        erase = erase_op_q;
        nvstr = 1'b1;
      end
      ST_PROG: begin
        xe    = 1'b1;
        ye    = 1'b1;
        prog  = 1'b1;
        nvstr = 1'b1;
      end
      ST_PGH: begin
        xe    = 1'b1;
        prog  = 1'b1;
        nvstr = 1'b1;
      end
      ST_ERASE: begin
        xe    = 1'b1;
        erase = 1'b1;
        nvstr = 1'b1;
      end
      ST_NVH: begin
        xe    = 1'b1;
        nvstr = 1'b1;
      end
      ST_RCV: xe = 1'b1;
`ifdef FLASH_PROG_VERIFY_EN
      ST_VSEL: begin
        xe = 1'b1;
        ye = 1'b1;
        se = 1'b1;
      end
      ST_VRD, ST_VCMP: begin
        xe = 1'b1;
        ye = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.ready = (state_q == ST_DONE);
  assign bus.error = (state_q == ST_DONE) && err_q;
  assign xadr      = row_q;
  assign yadr      = col_q;
  assign din       = data_q;

`ifndef FLASH_PROG_VERIFY_EN
  logic dout_unused;
  assign dout_unused = ^dout;
`endif

endmodule

// File: tb/tb_user_flash_programmer.sv
// Scoreboard bench for user_flash_programmer: random program/reject requests plus directed
// program, erase and reset cases, checked against timing derived from flash phase durations.
`timescale 1ns/1ps
module tb_user_flash_programmer;

  localparam int unsigned CLK_HZ = 400_000;

  function automatic int cyc(input longint t_ns);
    longint c;
    c = (t_ns * longint'(CLK_HZ) + 64'd999_999_999) / 64'd1_000_000_000;
    return (c < 1) ? 1 : int'(c);
  endfunction

  localparam int C_NVS   = cyc(5_000);
  localparam int C_PGS   = cyc(10_000);
  localparam int C_PROG  = cyc(16_000);
  localparam int C_NVH   = cyc(5_000);
  localparam int C_NVH1  = cyc(100_000);
  localparam int C_RCV   = cyc(10_000);
  localparam int C_RCVE  = cyc(50_000);
  localparam int C_ERASE = cyc(120_000_000);
`ifdef FLASH_PROG_VERIFY_EN
  localparam int C_VFY = 3;
`else
  localparam int C_VFY = 0;
`endif

  typedef struct {
    bit          is_erase;
    bit          is_reject;
    logic [8:0]  xadr;
    logic [5:0]  yadr;
    logic [31:0] din;
    bit          err;
    int          busy_lo, busy_hi;
    int          setup, ye, post, se;
    int          erase_lo, erase_hi;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        xe, ye, se, prog, erase, nvstr;
  logic [8:0]  xadr;
  logic [5:0]  yadr;
  logic [31:0] din, dout, dout_flip;

  always #5 clk = ~clk;

  user_flash_programmer_if bus ();

  assign dout = din ^ dout_flip;

  user_flash_programmer #(.CLK_FREQ(CLK_HZ)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .xe      (xe),
    .ye      (ye),
    .se      (se),
    .prog    (prog),
    .erase   (erase),
    .nvstr   (nvstr),
    .xadr    (xadr),
    .yadr    (yadr),
    .din     (din),
    .dout    (dout)
  );

  task automatic checkOutput(input string name, input longint actual, input longint lo, input longint hi);
    total++;
    if (actual < lo || actual > hi) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Monitor: accumulates per-operation observations, compares them with the queued expectation at ready.
  int m_busy, m_setup, m_ye, m_post, m_se, m_erase, m_act, m_idle_act;
  bit m_cap, m_unstable, m_overlap;
  logic [8:0]  c_x;
  logic [5:0]  c_y;
  logic [31:0] c_d;

  task automatic clearMonitor();
    m_busy = 0; m_setup = 0; m_ye = 0; m_post = 0; m_se = 0; m_erase = 0;
    m_act = 0; m_idle_act = 0; m_cap = 0; m_unstable = 0; m_overlap = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      clearMonitor();
    end else begin
      if (prog && erase) m_overlap = 1;
      if (bus.busy && !bus.ready) m_busy++;
      if ((prog || erase) && !nvstr) m_setup++;
      if (ye) m_ye++;
      if (se) m_se++;
      if (erase) m_erase++;
      if (nvstr && !prog && !erase) m_post++;
      if (xe || ye || se || prog || erase || nvstr) begin
        m_act++;
        if (!bus.busy) m_idle_act++;
      end
      if (xe) begin
        if (!m_cap) begin
          c_x = xadr; c_y = yadr; c_d = din; m_cap = 1;
        end else if (c_x != xadr || c_y != yadr || c_d != din) begin
          m_unstable = 1;
        end
      end
      if (bus.ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_ready", 1, 0, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("error", bus.error, e.err, e.err);
          checkOutput("busy_with_ready", bus.busy, 1, 1);
          checkOutput("busy_cycles", m_busy, e.busy_lo, e.busy_hi);
          checkOutput("idle_controls", m_idle_act, 0, 0);
          checkOutput("se_cycles", m_se, e.se, e.se);
          if (e.is_reject) begin
            checkOutput("reject_activity", m_act, 0, 0);
          end else begin
            checkOutput("xadr", c_x, e.xadr, e.xadr);
            if (!e.is_erase) begin
              checkOutput("yadr", c_y, e.yadr, e.yadr);
              checkOutput("din", c_d, e.din, e.din);
            end
            checkOutput("setup_cycles", m_setup, e.setup, e.setup);
            checkOutput("ye_cycles", m_ye, e.ye, e.ye);
            checkOutput("erase_cycles", m_erase, e.erase_lo, e.erase_hi);
            checkOutput("nvh_cycles", m_post, e.post, e.post);
            checkOutput("addr_stable", m_unstable, 0, 0);
            checkOutput("prog_erase_overlap", m_overlap, 0, 0);
          end
        end
        clearMonitor();
      end
    end
  end

  // Issues one request, queues its expected outcome, and optionally scrambles the bus while busy.
  task automatic applyStimulus(input bit es, input logic [3:0] ws, input logic [14:0] a,
                               input logic [31:0] d, input logic [31:0] flip, input bit toggle);
    exp_t e;
    int guard;
    @(negedge clk);
    e = '{default: 0};
    e.is_erase  = es;
    e.is_reject = !es && (ws != 4'hF);
    e.xadr = a[14:6];
    e.yadr = a[5:0];
    e.din  = d;
    e.err  = e.is_reject;
    if (e.is_reject) begin
      e.busy_lo = 0; e.busy_hi = 0;
    end else if (es) begin
      e.busy_lo  = C_NVS + C_ERASE + C_NVH1 + C_RCVE;
      e.busy_hi  = e.busy_lo + 2;
      e.setup    = C_NVS;
      e.erase_lo = C_NVS + C_ERASE;
      e.erase_hi = e.erase_lo + 2;
      e.post     = C_NVH1;
    end else begin
      e.busy_lo = C_NVS + C_PGS + C_PROG + 1 + C_NVH + C_RCV + C_VFY;
      e.busy_hi = e.busy_lo;
      e.setup   = C_NVS;
      e.ye      = C_PROG + C_VFY;
      e.post    = C_NVH;
`ifdef FLASH_PROG_VERIFY_EN
      e.se  = 1;
      e.err = (flip != 32'd0);
`endif
    end
    sb.push_back(e);
    dout_flip     = flip;
    bus.select    = 1'b1;
    bus.erase_sel = es;
    bus.wstrb     = ws;
    bus.addr      = a;
    bus.data_i    = d;
    @(negedge clk);
    guard = 0;
    while (!bus.ready && guard < 60_000) begin
      if (toggle) begin
        bus.select    = 1'($urandom);
        bus.erase_sel = 1'($urandom);
        bus.wstrb     = 4'($urandom);
        bus.addr      = 15'($urandom);
        bus.data_i    = $urandom;
      end else begin
        bus.select = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    bus.select = 1'b0;
    if (guard >= 60_000) checkOutput("ready_timeout", guard, 0, 59_999);
  endtask

  initial begin
    int guard;
    logic [3:0] ws;
    bus.select = 1'b0; bus.erase_sel = 1'b0; bus.wstrb = 4'h0;
    bus.addr = '0; bus.data_i = '0; dout_flip = '0;
    reset_n = 1'b0;
    #3;
    checkOutput("reset_outputs", {xe, ye, se, prog, erase, nvstr, bus.busy, bus.ready, bus.error}, 0, 0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    $display("[TB] directed program, reject, erase");

    applyStimulus(1'b0, 4'hF, 15'h0041, 32'hDEADBEEF, 32'd0, 1'b0);
    applyStimulus(1'b0, 4'h3, 15'h0041, 32'h12345678, 32'd0, 1'b0);
    applyStimulus(1'b0, 4'h0, 15'h7FFF, 32'hFFFFFFFF, 32'd0, 1'b0);
    applyStimulus(1'b0, 4'hF, 15'h7FFF, 32'hCAFEF00D, 32'h0000_0001, 1'b0);
    applyStimulus(1'b1, 4'h0, 15'h12C0, 32'h0, 32'd0, 1'b0);

    $display("[TB] reset during PROG");
    @(negedge clk);
    bus.select = 1'b1; bus.erase_sel = 1'b0; bus.wstrb = 4'hF;
    bus.addr = 15'h0123; bus.data_i = 32'h55AA55AA;
    @(negedge clk);
    bus.select = 1'b0;
    guard = 0;
    while (!ye && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("reached_prog", guard, 0, 199);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("reset_mid_prog", {xe, ye, se, prog, erase, nvstr, bus.busy, bus.ready, bus.error}, 0, 0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    applyStimulus(1'b0, 4'hF, 15'h0123, 32'h55AA55AA, 32'd0, 1'b0);

    $display("[TB] random requests");
    for (int i = 0; i < 50; i++) begin
      ws = ($urandom_range(3) != 0) ? 4'hF : 4'($urandom);
      applyStimulus(1'b0, ws, 15'($urandom), $urandom,
                    ($urandom_range(3) == 0) ? (32'd1 << $urandom_range(31)) : 32'd0, 1'b1);
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0, 0);
    checkOutput("idle_after_run", {bus.busy, xe, prog, erase}, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    bad++;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
